// File: rtl/loop_nest_counter_pkg.sv
// Shared types and defaults for the N-dimensional loop nest counter.
package loop_nest_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} lnc_state_e;

    localparam int LNC_NDIM   = 3;
    localparam int LNC_SIZE   = 12;
    localparam int LNC_ADDR_W = 32;

    typedef logic [LNC_SIZE-1:0] lnc_dim_t;

endpackage

// File: rtl/loop_nest_counter_stage.sv
// One dimension of the loop nest: index counter plus an incrementally
// maintained count*stride offset.
module loop_dim_stage
    import loop_nest_pkg::*;
#(
    parameter int SIZE   = LNC_SIZE,
    parameter int ADDR_W = LNC_ADDR_W
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              clr,
    input  logic              carry_in,
    input  logic [SIZE-1:0]   extent,
    input  logic [ADDR_W-1:0] stride,
    output logic [SIZE-1:0]   count,
    output logic [ADDR_W-1:0] offset,
    output logic              at_end,
    output logic              carry_out
);

    logic [SIZE-1:0]   count_q, count_d;
    logic [ADDR_W-1:0] offset_q, offset_d;

    // Extents 0 and 1 both pin the index at 0; avoids extent-1 underflow.
    assign at_end    = (extent <= SIZE'(1)) || (count_q == extent - SIZE'(1));
    assign carry_out = carry_in & at_end;
    assign count     = count_q;
    assign offset    = offset_q;

    always_comb begin
        count_d  = count_q;
        offset_d = offset_q;
        if (clr) begin
            count_d  = '0;
            offset_d = '0;
        end else if (carry_in) begin
            if (at_end) begin
                count_d  = '0;
                offset_d = '0;
            end else begin
                count_d  = count_q + SIZE'(1);
                offset_d = offset_q + stride;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count_q  <= '0;
            offset_q <= '0;
        end else begin
            count_q  <= count_d;
            offset_q <= offset_d;
        end
    end

endmodule

// File: rtl/loop_nest_counter.sv
// N-dimensional nested loop counter / address generator with valid-ready
// output, start/done sequencing and per-dimension last flags.
module loop_nest_counter
    import loop_nest_pkg::*;
#(
    parameter int NDIM   = LNC_NDIM,
    parameter int SIZE   = LNC_SIZE,
    parameter int ADDR_W = LNC_ADDR_W
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   clr,
    input  logic                   start,
    input  logic [NDIM*SIZE-1:0]   max,
    input  logic [NDIM*ADDR_W-1:0] stride,
    input  logic [ADDR_W-1:0]      base,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NDIM*SIZE-1:0]   count,
    output logic [ADDR_W-1:0]      addr,
    output logic [NDIM-1:0]        last,
    output logic                   busy,
    output logic                   done
);

    lnc_state_e state_q, state_d;

    logic [NDIM-1:0][SIZE-1:0]   max_q;
    logic [NDIM-1:0][ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0]           base_q;

    logic [NDIM-1:0][SIZE-1:0]   cnt;
    logic [NDIM-1:0][ADDR_W-1:0] off;
    logic [NDIM-1:0]             at_end;
    logic [NDIM-1:0]             end_pfx;
    logic [NDIM:0]               carry;
    logic                        running, step, load;
    logic [ADDR_W-1:0]           addr_sum;

    assign running   = (state_q == S_RUN);
    assign out_valid = running;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign step      = out_valid & out_ready;
    assign load      = (state_q == S_IDLE) & start & ~clr;
    assign carry[0]  = step;

    // carry[NDIM] is the step of the final beat: every dim wraps to 0 on it.
    for (genvar k = 0; k < NDIM; k++) begin : g_dim
        loop_dim_stage #(.SIZE(SIZE), .ADDR_W(ADDR_W)) u_stage (
            .aclk      (aclk),
            .aresetn   (aresetn),
            .clr       (clr),
            .carry_in  (carry[k]),
            .extent    (max_q[k]),
            .stride    (stride_q[k]),
            .count     (cnt[k]),
            .offset    (off[k]),
            .at_end    (at_end[k]),
            .carry_out (carry[k+1])
        );
    end

    always_comb begin
        logic acc;
        acc     = 1'b1;
        end_pfx = '0;
        for (int k = 0; k < NDIM; k++) begin
            acc        = acc & at_end[k];
            end_pfx[k] = acc;
        end
    end

    always_comb begin
        addr_sum = base_q;
        for (int k = 0; k < NDIM; k++) addr_sum = addr_sum + off[k];
    end

    // Outside RUN the offsets are already 0; gating base keeps addr at 0 too.
    assign addr  = running ? addr_sum : '0;
    assign count = cnt;
    assign last  = (running && !clr) ? end_pfx : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start)    state_d = S_RUN;
            S_RUN:   if (carry[NDIM]) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (clr) state_d = S_IDLE;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= S_IDLE;
            max_q    <= '0;
            stride_q <= '0;
            base_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                max_q    <= max;
                stride_q <= stride;
                base_q   <= base;
            end
        end
    end

endmodule

// File: tb/tb_loop_nest_counter.sv
// Directed bench for loop_nest_counter: hand-computed beat tables per scenario.
module tb_loop_nest_counter;

    localparam int NDIM = 3;
    localparam int SIZE = 12;
    localparam int AW   = 32;

    logic                 aclk = 1'b0;
    logic                 aresetn, clr, start, out_ready;
    logic [NDIM*SIZE-1:0] max_v;
    logic [NDIM*AW-1:0]   stride_v;
    logic [AW-1:0]        base_v;
    logic                 out_valid, busy, done;
    logic [NDIM*SIZE-1:0] count;
    logic [AW-1:0]        addr;
    logic [NDIM-1:0]      last;

    int n_chk = 0;
    int n_err = 0;

    logic [AW-1:0]        ea [0:15];
    logic [NDIM*SIZE-1:0] ec [0:15];
    logic [NDIM-1:0]      el [0:15];

    loop_nest_counter #(.NDIM(NDIM), .SIZE(SIZE), .ADDR_W(AW)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .clr       (clr),
        .start     (start),
        .max       (max_v),
        .stride    (stride_v),
        .base      (base_v),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .addr      (addr),
        .last      (last),
        .busy      (busy),
        .done      (done)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [NDIM*SIZE-1:0] pk3(input int d2, input int d1, input int d0);
        return {SIZE'(d2), SIZE'(d1), SIZE'(d0)};
    endfunction

    function automatic logic [NDIM*AW-1:0] st3(input int s2, input int s1, input int s0);
        return {AW'(s2), AW'(s1), AW'(s0)};
    endfunction

    task automatic set_beat(input int i, input logic [AW-1:0] a, input int d2, input int d1,
                            input int d0, input logic [NDIM-1:0] l);
        ea[i] = a;
        ec[i] = pk3(d2, d1, d0);
        el[i] = l;
    endtask

    // dim0: extent 2 stride 4; dim1: extent 3 stride 16; dim2: extent 2 stride 64
    task automatic cfg_test1();
        max_v    = pk3(2, 3, 2);
        stride_v = st3(64, 16, 4);
        base_v   = 32'h1000;
        set_beat(0,  32'h1000, 0, 0, 0, 3'b000);
        set_beat(1,  32'h1004, 0, 0, 1, 3'b001);
        set_beat(2,  32'h1010, 0, 1, 0, 3'b000);
        set_beat(3,  32'h1014, 0, 1, 1, 3'b001);
        set_beat(4,  32'h1020, 0, 2, 0, 3'b000);
        set_beat(5,  32'h1024, 0, 2, 1, 3'b011);
        set_beat(6,  32'h1040, 1, 0, 0, 3'b000);
        set_beat(7,  32'h1044, 1, 0, 1, 3'b001);
        set_beat(8,  32'h1050, 1, 1, 0, 3'b000);
        set_beat(9,  32'h1054, 1, 1, 1, 3'b001);
        set_beat(10, 32'h1060, 1, 2, 0, 3'b000);
        set_beat(11, 32'h1064, 1, 2, 1, 3'b111);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // rmode 0: ready always high; rmode 1: ready pattern 1-0-0-1 repeating
    task automatic run_beats(input string tag, input int n, input int rmode);
        int idx = 0;
        int cyc = 0;
        logic stalled = 1'b0;
        logic [AW-1:0] pa = '0;
        logic [NDIM*SIZE-1:0] pc = '0;
        logic rdy;
        while (idx < n && cyc < 200) begin
            rdy = (rmode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
            out_ready = rdy;
            chk({tag, ".valid"}, out_valid, 1'b1);
            chk({tag, ".addr"}, addr, ea[idx]);
            chk({tag, ".count"}, count, ec[idx]);
            chk({tag, ".last"}, last, el[idx]);
            if (stalled) begin
                chk({tag, ".hold_addr"}, addr, pa);
                chk({tag, ".hold_count"}, count, pc);
            end
            stalled = !rdy;
            pa = addr;
            pc = count;
            if (rdy) idx++;
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        chk({tag, ".nbeats"}, idx, n);
        chk({tag, ".done"}, done, 1'b1);
        chk({tag, ".done_valid"}, out_valid, 1'b0);
        chk({tag, ".done_count"}, count, '0);
        chk({tag, ".done_addr"}, addr, '0);
        chk({tag, ".done_last"}, last, '0);
        tick();
        chk({tag, ".post_done"}, done, 1'b0);
        chk({tag, ".post_busy"}, busy, 1'b0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, out_valid, 1'b0);
        chk({tag, ".busy"}, busy, 1'b0);
        chk({tag, ".done"}, done, 1'b0);
        chk({tag, ".count"}, count, '0);
        chk({tag, ".addr"}, addr, '0);
        chk({tag, ".last"}, last, '0);
    endtask

    initial begin
        aresetn   = 1'b0;
        clr       = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        max_v     = '0;
        stride_v  = '0;
        base_v    = '0;
        #12;
        chk_idle("reset");
        @(posedge aclk);
        #1 aresetn = 1'b1;
        tick();
        chk_idle("idle");

        // Test 1: free-running 12 beats
        cfg_test1();
        pulse_start();
        run_beats("t1", 12, 0);

        // Test 2: same config with backpressure
        pulse_start();
        run_beats("t2", 12, 1);

        // Test 3: extent-1 and extent-0 inner dims, outer dim of 4 with stride 1
        max_v    = pk3(4, 0, 1);
        stride_v = st3(1, 0, 8);
        base_v   = 32'h200;
        for (int i = 0; i < 4; i++)
            set_beat(i, 32'h200 + i, i, 0, 0, (i == 3) ? 3'b111 : 3'b011);
        pulse_start();
        run_beats("t3", 4, 0);

        // Test 4: clr on beat 5 aborts; restart replays from the base
        cfg_test1();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            chk("t4.addr", addr, ea[i]);
            tick();
        end
        chk("t4.beat5", addr, ea[4]);
        clr = 1'b1;
        #1;
        chk("t4.clr_last", last, '0);
        tick();
        clr = 1'b0;
        chk_idle("t4.abort");
        tick();
        chk("t4.no_done", done, 1'b0);
        pulse_start();
        run_beats("t4.replay", 12, 0);

        // Test 5: start during RUN ignored; clr+start in IDLE ignored
        pulse_start();
        out_ready = 1'b0;
        max_v  = pk3(1, 1, 1);
        base_v = 32'h2000;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("t5.busy", busy, 1'b1);
        chk("t5.addr", addr, 32'h1000);
        run_beats("t5", 12, 0);
        clr   = 1'b1;
        start = 1'b1;
        tick();
        clr   = 1'b0;
        start = 1'b0;
        chk_idle("t5.clrstart");
        tick();
        chk("t5.still_idle", busy, 1'b0);

        // Test 6: async reset mid-run, then address wrap past 2^32
        cfg_test1();
        pulse_start();
        tick();
        tick();
        aresetn = 1'b0;
        #1;
        chk_idle("t6.rst");
        tick();
        aresetn = 1'b1;
        tick();
        chk_idle("t6.after_rst");
        max_v    = pk3(3, 1, 1);
        stride_v = st3(4, 4, 4);
        base_v   = 32'hFFFF_FFF8;
        set_beat(0, 32'hFFFF_FFF8, 0, 0, 0, 3'b011);
        set_beat(1, 32'hFFFF_FFFC, 1, 0, 0, 3'b011);
        set_beat(2, 32'h0000_0000, 2, 0, 0, 3'b111);
        pulse_start();
        run_beats("t6", 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
